// File: rtl/mash_nstage.sv
// Cascaded first-order error-feedback (MASH) sigma-delta modulator, 1..3 stages,
// with AXI-stream style in/out handshakes and optional LFSR dither on stage 1.
module mash_nstage #(
  parameter int WIDTH  = 16,
  parameter int ORDER  = 3,
  parameter int DITHER = 0,
  localparam int OUT_BW = ORDER + 1
) (
  input  logic              aclk,
  input  logic              arst_n,
  input  logic [WIDTH-1:0]  s_axis_data_tdata,
  input  logic              s_axis_data_tvalid,
  output logic              s_axis_data_tready,
  output logic [OUT_BW-1:0] m_axis_data_tdata,
  output logic [WIDTH-1:0]  m_axis_data_terror,
  output logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready
);

  if (ORDER < 1 || ORDER > 3) begin : g_bad_order
    $error("mash_nstage: ORDER must be 1..3");
  end
  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("mash_nstage: WIDTH must be 4..32");
  end

  // Handshake: a sample is accepted when s_tvalid && s_tready; the output
  // register transfers when m_tvalid && m_tready; s_tready is free whenever
  // the output register is empty or draining this cycle.
  logic accept;
  logic dither;

  logic [WIDTH-1:0]  acc_q    [ORDER];
  logic [WIDTH-1:0]  acc_d    [ORDER];
  logic [WIDTH-1:0]  acc_next [ORDER];
  logic [2:0]        carry;
  logic              c2d1_q, c2d1_d;
  logic              c3d1_q, c3d1_d;
  logic              c3d2_q, c3d2_d;
  logic [3:0]        y_full;
  logic [OUT_BW-1:0] tdata_q, tdata_d;
  logic [WIDTH-1:0]  terror_q, terror_d;
  logic              tvalid_q, tvalid_d;

  assign s_axis_data_tready = !tvalid_q || m_axis_data_tready;
  assign accept             = s_axis_data_tvalid && s_axis_data_tready;

  // All stages ripple within one cycle; each feeds its new accumulator forward.
  always_comb begin
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] stage_in;
    stage_in = s_axis_data_tdata;
    sum      = '0;
    carry    = '0;
    for (int k = 0; k < ORDER; k++) begin
      sum = {1'b0, stage_in} + {1'b0, acc_q[k]}
          + {{WIDTH{1'b0}}, ((k == 0) && dither)};
      carry[k]    = sum[WIDTH];
      acc_next[k] = sum[WIDTH-1:0];
      stage_in    = sum[WIDTH-1:0];
    end
  end

  // Noise-cancelling recombination in 4-bit two's complement (range -3..+4).
  always_comb begin
    y_full = {3'b0, carry[0]}
           + {3'b0, carry[1]} - {3'b0, c2d1_q}
           + {3'b0, carry[2]} - {2'b0, c3d1_q, 1'b0} + {3'b0, c3d2_q};
  end

  always_comb begin
    for (int k = 0; k < ORDER; k++) begin
      acc_d[k] = accept ? acc_next[k] : acc_q[k];
    end
    c2d1_d   = accept ? carry[1] : c2d1_q;
    c3d1_d   = accept ? carry[2] : c3d1_q;
    c3d2_d   = accept ? c3d1_q   : c3d2_q;
    tdata_d  = accept ? y_full[OUT_BW-1:0] : tdata_q;
    terror_d = accept ? acc_next[ORDER-1]  : terror_q;
    if (accept)                  tvalid_d = 1'b1;
    else if (m_axis_data_tready) tvalid_d = 1'b0;
    else                         tvalid_d = tvalid_q;
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      acc_q    <= '{default: '0};
      c2d1_q   <= 1'b0;
      c3d1_q   <= 1'b0;
      c3d2_q   <= 1'b0;
      tdata_q  <= '0;
      terror_q <= '0;
      tvalid_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      c2d1_q   <= c2d1_d;
      c3d1_q   <= c3d1_d;
      c3d2_q   <= c3d2_d;
      tdata_q  <= tdata_d;
      terror_q <= terror_d;
      tvalid_q <= tvalid_d;
    end
  end

  // 23-bit Fibonacci LFSR, x^23 + x^18 + 1; bit 0 is the stage-1 carry-in.
  if (DITHER != 0) begin : g_dither
    logic [22:0] lfsr_q, lfsr_d;
    always_comb begin
      lfsr_d = accept ? {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]} : lfsr_q;
    end
    always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) lfsr_q <= 23'd1;
      else         lfsr_q <= lfsr_d;
    end
    assign dither = lfsr_q[0];
  end else begin : g_no_dither
    assign dither = 1'b0;
  end

  assign m_axis_data_tdata  = tdata_q;
  assign m_axis_data_terror = terror_q;
  assign m_axis_data_tvalid = tvalid_q;

endmodule

// File: doc/mash_nstage.md
MASH_NSTAGE -- requirements
Module: mash_nstage

Interface
REQ-001 SHALL have parameter WIDTH, default 16: input word width and accumulator width per stage (4..32).
REQ-002 SHALL have parameter ORDER, default 3: number of cascaded first-order error-feedback stages (1..3); other values are a compile-time error.
REQ-003 SHALL have parameter DITHER, default 0: 1 enables an LFSR dither bit on stage 1; 0 disables it.
REQ-004 SHALL have derived parameter OUT_BW = ORDER+1: signed output width.
REQ-005 aclk  input  1  sole clock; all state updates on its rising edge.
REQ-006 arst_n  input  1  asynchronous active-low reset: assertion clears state immediately; deassertion is synchronised by the integrator.
REQ-007 s_axis_data_tdata  input  WIDTH  unsigned input sample.
REQ-008 s_axis_data_tvalid  input  1  input sample valid.
REQ-009 s_axis_data_tready  output  1  block can accept a sample.
REQ-010 m_axis_data_tdata  output  OUT_BW  signed two's-complement noise-cancelled modulator output.
REQ-011 m_axis_data_terror  output  WIDTH  last-stage accumulator residue after the accepted sample.
REQ-012 m_axis_data_tvalid  output  1  output valid.
REQ-013 m_axis_data_tready  input  1  downstream accepts output.

Function
REQ-014 Accept occurs on a cycle where s_axis_data_tvalid and s_axis_data_tready are both 1; all state SHALL change only on accept, except m_axis_data_tvalid.
REQ-015 s_axis_data_tready SHALL equal (!m_axis_data_tvalid || m_axis_data_tready), combinationally.
REQ-016 Stage k (k=1..ORDER) SHALL compute sum_k = in_k + acc_k in WIDTH+1 bits; carry c_k = sum_k[WIDTH]; acc_k <= sum_k[WIDTH-1:0] on accept.
REQ-017 in_1 = s_axis_data_tdata plus the dither bit (when DITHER=1) as carry-in; in_k = acc_(k-1) next value (low WIDTH bits of sum_(k-1)) for k>1; all stages SHALL be evaluated in the same cycle.
REQ-018 Output on accept SHALL be y = c1 + (c2 - c2d1) + (c3 - 2*c3d1 + c3d2), where dN is the carry from the N-th previous accepted sample; terms for absent stages are 0.
REQ-019 Carry history registers c2d1, c3d1, c3d2 SHALL shift only on accept.
REQ-020 y SHALL be registered into m_axis_data_tdata on accept; latency is one aclk cycle from accept to valid output.
REQ-021 m_axis_data_tvalid SHALL be set on accept, cleared when (m_axis_data_tready && no accept), and held with data stable while m_axis_data_tready=0.
REQ-022 Simultaneous output drain and new accept SHALL load the new sample with tvalid remaining 1 (full throughput, one sample per cycle).
REQ-023 m_axis_data_terror SHALL register acc_ORDER next value on accept.
REQ-024 Dither LFSR: 23-bit Fibonacci, taps x^23+x^18+1, seed 1, advances on accept only; its bit 0 is the dither bit; absent when DITHER=0.
REQ-025 Accumulators SHALL wrap modulo 2^WIDTH; no saturation anywhere; y range for ORDER=3 is -3..+4.

Reset
REQ-026 On arst_n=0, all acc_k, carry history, and m_axis_data_terror SHALL be 0, m_axis_data_tdata 0, m_axis_data_tvalid 0, and LFSR = 1.
REQ-027 During reset, s_axis_data_tready SHALL read 1 (from tvalid=0) but no accept takes effect.
REQ-028 Reset asserted mid-stream SHALL discard the held output and all history; the first post-reset output SHALL match a cold start.

Verification
REQ-029 ORDER=1, WIDTH=4, DITHER=0, tdata=8 every cycle, tready=1 -> outputs 0,1,0,1,... from first valid, terror 8,0,8,0.
REQ-030 ORDER=3, WIDTH=16, DITHER=0, tdata=0x4000 for 4096 samples -> sum of y = 1024 +/-3, every y within -3..+4.
REQ-031 Any ORDER, tdata=0, DITHER=0 -> y=0 and terror=0 on every output.
REQ-032 Backpressure: m_axis_data_tready=0 for 10 cycles with tvalid=1 -> s_axis_data_tready=0, output and terror frozen; upon release, sequence identical to a non-stalled reference run.
REQ-033 Reset pulse after 100 samples, then same stimulus -> output sequence bit-identical to the first 100 outputs of a cold run.
REQ-034 ORDER=3 output stream vs. a bit-accurate reference model over 10^5 random inputs, random tvalid/tready -> zero mismatches.
